// File: rtl/dram_iaram_packer_if.sv
// Element-in / beat-out stream bundle for the IARAM packer.
// master drives elements and beat ready; slave is the packer.
interface dram_iaram_packer_if #(
  parameter int NUM_DATA = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4,
  parameter int CH_W     = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [IDX_W-1:0]           in_index;
  logic                       in_zero;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_DATA*DATA_W-1:0] out_data;
  logic [NUM_DATA*IDX_W-1:0]  out_indices;
  logic [NUM_DATA-1:0]        out_mask;
  logic [CH_W-1:0]            out_channel;
  logic                       out_last;

  modport master (
    output in_valid, in_data, in_index,
    output in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_indices, out_mask,
    input  out_channel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_index,
    input  in_zero, in_last, out_ready,
    output in_ready, out_valid, out_data,
    output out_indices, out_mask,
    output out_channel, out_last
  );
endinterface

// File: rtl/dram_iaram_packer.sv
// Packs per-channel compressed elements into masked IARAM beats.
// Optional PACKER_STATS_EN adds beat/element counters.
module dram_iaram_packer #(
  parameter int NUM_DATA = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4,
  parameter int CH_W     = 4,
  parameter int MAX_COMP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W:0]     num_channels,
  dram_iaram_packer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              overflow_err
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]       stat_beats,
  output logic [15:0]       stat_elems
`endif
);

  localparam int FW = $clog2(NUM_DATA + 1);
  localparam int EW = $clog2(MAX_COMP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [EW-1:0]     elem_cnt_q, elem_cnt_d;
  logic [CH_W:0]     chan_cnt_q, chan_cnt_d;
  logic [CH_W:0]     num_ch_q, num_ch_d;
  logic [DATA_W-1:0] data_q [NUM_DATA];
  logic [DATA_W-1:0] data_d [NUM_DATA];
  logic [IDX_W-1:0]  idx_q  [NUM_DATA];
  logic [IDX_W-1:0]  idx_d  [NUM_DATA];
  logic [NUM_DATA-1:0] mask_q, mask_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              send;
  logic              beat_hs;

  assign send    = (state_q == S_SEND);
  assign beat_hs = send && bus.out_ready;

  // next-state, slot fill and handshake bookkeeping
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    elem_cnt_d   = elem_cnt_q;
    chan_cnt_d   = chan_cnt_q;
    num_ch_d     = num_ch_q;
    data_d       = data_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    bus.in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_ch_d   = num_channels;
          chan_cnt_d = '0;
          elem_cnt_d = '0;
          fill_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = (num_channels == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (!bus.in_zero) begin
            if (elem_cnt_q < EW'(MAX_COMP)) begin
              for (int i = 0; i < NUM_DATA; i++) begin
                if (fill_cnt_q == FW'(i)) begin
                  data_d[i] = bus.in_data;
                  idx_d[i]  = bus.in_index;
                  mask_d[i] = 1'b1;
                end
              end
              fill_cnt_d = fill_cnt_q + FW'(1);
              elem_cnt_d = elem_cnt_q + EW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (fill_cnt_d == FW'(NUM_DATA) || bus.in_last) begin
            last_d  = bus.in_last;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          fill_cnt_d = '0;
          mask_d     = '0;
          last_d     = 1'b0;
          for (int i = 0; i < NUM_DATA; i++) begin
            data_d[i] = '0;
            idx_d[i]  = '0;
          end
          state_d = S_FILL;
          if (last_q) begin
            elem_cnt_d = '0;
            chan_cnt_d = chan_cnt_q + 1'b1;
            if (chan_cnt_q + 1'b1 == num_ch_q) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= '0;
      elem_cnt_q <= '0;
      chan_cnt_q <= '0;
      num_ch_q   <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < NUM_DATA; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      elem_cnt_q <= elem_cnt_d;
      chan_cnt_q <= chan_cnt_d;
      num_ch_q   <= num_ch_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < NUM_DATA; i++) begin
        data_q[i] <= data_d[i];
        idx_q[i]  <= idx_d[i];
      end
    end
  end

  // beat presentation, blanked outside SEND
  always_comb begin
    bus.out_data    = '0;
    bus.out_indices = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      if (send) begin
        bus.out_data[i*DATA_W +: DATA_W] = data_q[i];
        bus.out_indices[i*IDX_W +: IDX_W] = idx_q[i];
      end
    end
    bus.out_valid   = send;
    bus.out_mask    = send ? mask_q : '0;
    bus.out_last    = send & last_q;
    bus.out_channel = send ? chan_cnt_q[CH_W-1:0] : '0;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign overflow_err = ovf_q;

`ifdef PACKER_STATS_EN
  logic [15:0] stat_beats_q, stat_beats_d;
  logic [15:0] stat_elems_q, stat_elems_d;
  logic [16:0] elem_sum;

  // saturating beat / element counters
  always_comb begin
    stat_beats_d = stat_beats_q;
    stat_elems_d = stat_elems_q;
    elem_sum     = {1'b0, stat_elems_q};
    for (int i = 0; i < NUM_DATA; i++) begin
      elem_sum = elem_sum + 17'(mask_q[i]);
    end
    if (state_q == S_IDLE && start) begin
      stat_beats_d = '0;
      stat_elems_d = '0;
    end else if (beat_hs) begin
      if (stat_beats_q != 16'hFFFF) begin
        stat_beats_d = stat_beats_q + 16'd1;
      end
      stat_elems_d = elem_sum[16] ? 16'hFFFF : elem_sum[15:0];
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_elems_q <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_elems_q <= stat_elems_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_elems = stat_elems_q;
`else
  logic unused_hs;
  assign unused_hs = beat_hs;
`endif

endmodule
